// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : arb_pkg                                                 |
// | Description: Shared types, default constants and helpers for the     |
// |              rr_arbiter_n round-robin arbiter.                       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package arb_pkg;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Binary index of a one-hot (or zero) vector of up to 32 bits.
    // OR-ing the indices of set bits is exact for one-hot inputs and
    // yields 0 for an all-zero input.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | int'(i);
            end
        end
        return idx;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : rr_arbiter_n_if                                         |
// | Description: Request/grant bundle between the bus masters and the    |
// |              round-robin arbiter.                                    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface rr_arbiter_n_if #(
    parameter int N = 4
) ();
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;

    // Requester side: drives requests, observes grants
    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx
    );

    // Arbiter side: observes requests, drives grants
    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx
    );
endinterface : rr_arbiter_n_if
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rr_pick                                                 |
// | Description: Combinational rotate-priority picker. Returns the first |
// |              set request at or above 'start', wrapping at N.         |
// |              Supports N up to 32.                                    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module rr_pick
    import arb_pkg::*;
#(
    parameter int N     = ARB_N_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Walk the request vector from 'start' with wrap; first hit wins
    always_comb begin
        int j;
        j     = 0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign idx = IDX_W'(onehot_to_idx(32'(pick)));

endmodule : rr_pick
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rr_arbiter_n                                            |
// | Description: N-requester round-robin arbiter with registered one-hot |
// |              grant, bounded hold time and zero-bubble hand-over.     |
// |              Optional macro ARB_PRIO_MODE_EN adds a prio_mode input  |
// |              that switches to fixed lowest-index-first priority.     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int IDX_W    = $clog2(N)
) (
    input  wire logic        clk,
    input  wire logic        rst,
`ifdef ARB_PRIO_MODE_EN
    input  wire logic        prio_mode,
`endif
    rr_arbiter_n_if.slave    bus
);

    localparam int               CNT_W     = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N - 1);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     gnt_q,   gnt_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             prio_sel;
    logic [IDX_W-1:0] start_idx;
    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             owner_req;

`ifdef ARB_PRIO_MODE_EN
    assign prio_sel = prio_mode;
`else
    assign prio_sel = 1'b0;
`endif

    // Search origin: index 0 in priority mode, otherwise one past the last
    // grant. While granting, ptr_q equals the owner, so this also covers
    // the "re-arbitrate from owner+1" case.
    always_comb begin
        start_idx = '0;
        if (!prio_sel && (ptr_q != IDX_LAST)) begin
            start_idx = ptr_q + 1'b1;
        end
    end

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (bus.req),
        .start (start_idx),
        .pick  (pick_oh),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign owner_req = bus.req[idx_q];

    // State and grant registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= IDX_LAST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: keep the owner until it drops or its hold expires; any
    // re-arbitration takes the picker result directly, so a waiting
    // requester is granted on the same edge with no idle cycle. When the
    // owner is the only requester at expiry the picker returns the owner
    // itself, which keeps the grant and restarts the counter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_GRANT;
                    gnt_d   = pick_oh;
                    idx_d   = pick_idx;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ARB_GRANT: begin
                if (owner_req && (cnt_q < HOLD_LAST)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (pick_found) begin
                    gnt_d = pick_oh;
                    idx_d = pick_idx;
                    ptr_d = pick_idx;
                    cnt_d = '0;
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come straight from registers; no request-to-grant path
    always_comb begin
        bus.gnt       = gnt_q;
        bus.gnt_valid = (state_q == ARB_GRANT);
        bus.gnt_idx   = idx_q;
    end

endmodule : rr_arbiter_n
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_rr_arbiter_n                                         |
// | Description: Self-checking bench for rr_arbiter_n (N=4, MAX_HOLD=4): |
// |              directed vector table plus randomized traffic against   |
// |              a behavioural reference model.                          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_rr_arbiter_n;

    localparam int N    = 4;
    localparam int MAXH = 4;

    logic       clk;
    logic       rst;
    logic       prio_mode;

    rr_arbiter_n_if #(.N(N)) bus ();

    rr_arbiter_n #(
        .N        (N),
        .MAX_HOLD (MAXH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ARB_PRIO_MODE_EN
        .prio_mode (prio_mode),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: owner -1 means idle
    int m_owner;
    int m_ptr;
    int m_hold;
    logic [3:0] last_req;

    function automatic void add(input logic r, input logic [3:0] q,
                                input logic [3:0] g, input logic [1:0] i);
        vec_t v;
        v.rst = r;
        v.req = q;
        v.gnt = g;
        v.idx = i;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level arbitration rules, evaluated once per edge
    task automatic model_step(input logic r, input logic p, input logic [3:0] q);
        int start;
        int found;
        logic pe;
`ifdef ARB_PRIO_MODE_EN
        pe = p;
`else
        pe = 1'b0;
`endif
        if (r) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_hold  = 0;
        end else if (m_owner >= 0 && q[m_owner] && m_hold < MAXH - 1) begin
            m_hold = m_hold + 1;
        end else begin
            if (pe)               start = 0;
            else if (m_owner >= 0) start = (m_owner + 1) % N;
            else                   start = (m_ptr + 1) % N;
            found = -1;
            for (int k = 0; k < N; k++) begin
                if (found < 0 && q[(start + k) % N]) found = (start + k) % N;
            end
            if (found >= 0) begin
                m_owner = found;
                m_ptr   = found;
                m_hold  = 0;
            end else begin
                m_owner = -1;
                m_hold  = 0;
            end
        end
    endtask

    task automatic apply(input logic r, input logic p, input logic [3:0] q);
        rst       = r;
        prio_mode = p;
        bus.req   = q;
        last_req  = q;
        @(posedge clk);
        #1;
        model_step(r, p, q);
    endtask

    task automatic check_model(input string tag);
        logic [3:0] one;
        logic [3:0] exp_g;
        one   = 4'b0001;
        exp_g = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
        check({tag, "_gnt"},   32'(bus.gnt),       32'(exp_g));
        check({tag, "_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
        check({tag, "_idx"},   32'(bus.gnt_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check({tag, "_onehot"}, 32'($countones(bus.gnt) <= 1), 32'd1);
        check({tag, "_reqd"},  32'(bus.gnt & ~last_req), 32'd0);
    endtask

    initial begin
        logic [3:0] cur_req;
        logic       cur_prio;
        logic [3:0] one;
        n_tests   = 0;
        n_fail    = 0;
        m_owner   = -1;
        m_ptr     = N - 1;
        m_hold    = 0;
        rst       = 1'b1;
        prio_mode = 1'b0;
        bus.req   = '0;
        last_req  = '0;
        one       = 4'b0001;

        // Reset held with all requesting
        add(1'b1, 4'hF, 4'h0, 2'd0);
        add(1'b1, 4'hF, 4'h0, 2'd0);
        // Full contention: each owner for MAX_HOLD cycles, then wrap
        for (int g = 0; g < N; g++) begin
            for (int c = 0; c < MAXH; c++) add(1'b0, 4'hF, one << g, 2'(g));
        end
        add(1'b0, 4'hF, 4'h1, 2'd0);
        // Sole requester never loses the grant at hold expiry
        for (int c = 0; c < 10; c++) add(1'b0, 4'h4, 4'h4, 2'd2);
        // Zero-bubble hand-over 0010 -> 1000
        add(1'b0, 4'h2, 4'h2, 2'd1);
        add(1'b0, 4'hA, 4'h2, 2'd1);
        add(1'b0, 4'h8, 4'h8, 2'd3);
        // Idle with pointer retention, then wrap search from 3 to 0
        add(1'b0, 4'h4, 4'h4, 2'd2);
        add(1'b0, 4'h0, 4'h0, 2'd0);
        add(1'b0, 4'h3, 4'h1, 2'd0);
        // Reset mid-grant restores pointer to N-1
        add(1'b0, 4'h4, 4'h4, 2'd2);
        add(1'b1, 4'h4, 4'h0, 2'd0);
        add(1'b0, 4'h6, 4'h2, 2'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, 1'b0, vecs[i].req);
            check($sformatf("vec%0d_gnt", i),   32'(bus.gnt),       32'(vecs[i].gnt));
            check($sformatf("vec%0d_valid", i), 32'(bus.gnt_valid), 32'(|vecs[i].gnt));
            check($sformatf("vec%0d_idx", i),   32'(bus.gnt_idx),   32'(vecs[i].idx));
        end

`ifdef ARB_PRIO_MODE_EN
        // Fixed priority: lowest index keeps the grant through expiry
        apply(1'b1, 1'b1, 4'hF);
        for (int c = 0; c < 10; c++) begin
            apply(1'b0, 1'b1, 4'hF);
            check($sformatf("prio%0d_gnt", c), 32'(bus.gnt), 32'h1);
        end
`endif

        // Randomized traffic with sticky requests so hold expiry is exercised
        apply(1'b1, 1'b0, 4'h0);
        cur_req  = 4'h0;
        cur_prio = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) cur_req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) cur_prio = ~cur_prio;
            apply(($urandom_range(0, 59) == 0), cur_prio, cur_req);
            check_model($sformatf("rnd%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_arbiter_n
`default_nettype wire
